// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: multi-stage forwarding, load-use stall and redirect flush control for the RV32 pipeline
module pipe_hazard_ctrl #(
  parameter int NUM_FWD_STAGES = 2,
  parameter int LOAD_LAT = 1,
  parameter int FLUSH_SLOTS = 1,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W = 32,
  localparam int FW = $clog2(NUM_FWD_STAGES + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_wr,
  input  logic                  id_mem_read,
  input  logic                  redirect,
  input  logic                  ext_stall,
  output logic [FW-1:0]         fwd_sel_1,
  output logic [FW-1:0]         fwd_sel_2,
  output logic                  stall_if,
  output logic                  flush_id,
  output logic                  issue,
  output logic [CNT_W-1:0]      stall_count
);
  localparam int N = NUM_FWD_STAGES;
  logic [N:1] s_v, s_w, s_ld;
  logic [REG_ADDR_W-1:0] s_rd [1:N];
  logic [2:0] flush_cnt;
  logic lu1, lu2, load_use, flush_active;
  // oldest-to-youngest scan so the youngest matching producer wins
  always_comb begin
    fwd_sel_1 = '0;
    fwd_sel_2 = '0;
    lu1 = 1'b0;
    lu2 = 1'b0;
    for (int k = N; k >= 1; k--) begin
      if (id_rs1_used && id_rs1 != '0 && s_v[k] && s_w[k] && s_rd[k] == id_rs1) begin
        lu1 = s_ld[k] && k <= LOAD_LAT;
        fwd_sel_1 = lu1 ? '0 : FW'(k);
      end
      if (id_rs2_used && id_rs2 != '0 && s_v[k] && s_w[k] && s_rd[k] == id_rs2) begin
        lu2 = s_ld[k] && k <= LOAD_LAT;
        fwd_sel_2 = lu2 ? '0 : FW'(k);
      end
    end
    load_use = lu1 | lu2;
    flush_active = redirect | (flush_cnt != '0);
    issue = id_valid & ~ext_stall & ~load_use & ~flush_active;
    flush_id = flush_active & ~ext_stall;
    stall_if = ext_stall | (load_use & id_valid & ~flush_active);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      s_v <= '0;
      flush_cnt <= '0;
      stall_count <= '0;
    end else begin
      if (stall_if && !(&stall_count)) stall_count <= stall_count + CNT_W'(1);
      if (!ext_stall) begin
        for (int k = N; k >= 2; k--) begin
          s_v[k] <= s_v[k-1];
          s_w[k] <= s_w[k-1];
          s_ld[k] <= s_ld[k-1];
          s_rd[k] <= s_rd[k-1];
        end
        s_v[1] <= issue;
        s_w[1] <= id_reg_wr;
        s_ld[1] <= id_mem_read;
        s_rd[1] <= id_rd;
        flush_cnt <= redirect ? 3'(FLUSH_SLOTS - 1) : flush_cnt - 3'(flush_cnt != '0);
      end
    end
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed stimulus, per-cycle model comparison plus hand-computed spot checks
module tb_pipe_hazard_ctrl;
  localparam int N = 2, LL = 1, FS = 2;
  logic clk = 0, reset = 1;
  logic id_valid = 0, id_rs1_used = 0, id_rs2_used = 0, id_reg_wr = 0, id_mem_read = 0;
  logic redirect = 0, ext_stall = 0;
  logic [4:0] id_rs1 = 0, id_rs2 = 0, id_rd = 0;
  logic [1:0] fwd_sel_1, fwd_sel_2;
  logic stall_if, flush_id, issue;
  logic [31:0] stall_count;
  int total = 0, passed = 0;
  bit chk_en = 0;
  always #5 clk = ~clk;
  pipe_hazard_ctrl #(.NUM_FWD_STAGES(N), .LOAD_LAT(LL), .FLUSH_SLOTS(FS), .REG_ADDR_W(5), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd), .id_reg_wr(id_reg_wr),
    .id_mem_read(id_mem_read), .redirect(redirect), .ext_stall(ext_stall),
    .fwd_sel_1(fwd_sel_1), .fwd_sel_2(fwd_sel_2), .stall_if(stall_if), .flush_id(flush_id),
    .issue(issue), .stall_count(stall_count));
  typedef struct {bit v; bit [4:0] rd; bit w; bit ld;} ent_t;
  ent_t m [1:N];
  int mcnt = 0;
  longint mstall = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask
  function automatic int youngest(input logic [4:0] rs, input logic used);
    if (!used || rs == 0) return 0;
    for (int k = 1; k <= N; k++) if (m[k].v && m[k].w && m[k].rd == rs) return k;
    return 0;
  endfunction
  function automatic bit hazard(input int k);
    return k != 0 && m[k].ld && k <= LL;
  endfunction
  function automatic void model(output int s1, output int s2, output bit st, output bit fl, output bit is);
    int k1, k2;
    bit lu, fa;
    k1 = youngest(id_rs1, id_rs1_used);
    k2 = youngest(id_rs2, id_rs2_used);
    lu = hazard(k1) || hazard(k2);
    s1 = hazard(k1) ? 0 : k1;
    s2 = hazard(k2) ? 0 : k2;
    fa = redirect || mcnt != 0;
    is = id_valid && !ext_stall && !lu && !fa;
    fl = fa && !ext_stall;
    st = ext_stall || (lu && id_valid && !fa);
  endfunction
  always @(posedge clk) begin
    int s1, s2;
    bit st, fl, is;
    model(s1, s2, st, fl, is);
    if (reset) begin
      for (int k = 1; k <= N; k++) m[k] = '{0, 0, 0, 0};
      mcnt = 0;
      mstall = 0;
    end else begin
      if (st && mstall < 64'hFFFF_FFFF) mstall++;
      if (!ext_stall) begin
        for (int k = N; k > 1; k--) m[k] = m[k-1];
        m[1] = is ? '{1'b1, id_rd, id_reg_wr, id_mem_read} : '{0, 0, 0, 0};
        mcnt = redirect ? FS - 1 : (mcnt > 0 ? mcnt - 1 : 0);
      end
    end
  end
  always @(negedge clk) begin
    int s1, s2;
    bit st, fl, is;
    if (chk_en) begin
      model(s1, s2, st, fl, is);
      chk("fwd_sel_1", 32'(fwd_sel_1), 32'(s1));
      chk("fwd_sel_2", 32'(fwd_sel_2), 32'(s2));
      chk("stall_if", 32'(stall_if), 32'(st));
      chk("flush_id", 32'(flush_id), 32'(fl));
      chk("issue", 32'(issue), 32'(is));
      chk("stall_count", stall_count, mstall[31:0]);
    end
  end
  task automatic setin(input bit v, input int r1, input bit u1, input int r2, input bit u2,
                       input int rd, input bit wr, input bit ld, input bit rdir, input bit xs);
    id_valid = v; id_rs1 = 5'(r1); id_rs1_used = u1; id_rs2 = 5'(r2); id_rs2_used = u2;
    id_rd = 5'(rd); id_reg_wr = wr; id_mem_read = ld; redirect = rdir; ext_stall = xs;
  endtask
  task automatic drive(input bit v, input int r1, input bit u1, input int r2, input bit u2,
                       input int rd, input bit wr, input bit ld, input bit rdir, input bit xs);
    @(posedge clk);
    #1 setin(v, r1, u1, r2, u2, rd, wr, ld, rdir, xs);
    @(negedge clk);
  endtask
  task automatic nop();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 0;
    chk_en = 1;
    @(negedge clk);
    chk("rst sel1", 32'(fwd_sel_1), 0);
    chk("rst stall", 32'(stall_if), 0);
    chk("rst flush", 32'(flush_id), 0);
    chk("rst issue", 32'(issue), 0);
    chk("rst count", stall_count, 0);
    // addi x5,x1 then add x7,x5,x5
    drive(1, 1, 1, 0, 0, 5, 1, 0, 0, 0);
    chk("t1 issue0", 32'(issue), 1);
    drive(1, 5, 1, 5, 1, 7, 1, 0, 0, 0);
    chk("t1 sel1", 32'(fwd_sel_1), 1);
    chk("t1 sel2", 32'(fwd_sel_2), 1);
    chk("t1 stall", 32'(stall_if), 0);
    chk("t1 issue", 32'(issue), 1);
    nop(); nop();
    // lw x6 then add x7,x6,x1
    drive(1, 2, 1, 0, 0, 6, 1, 1, 0, 0);
    drive(1, 6, 1, 1, 1, 7, 1, 0, 0, 0);
    chk("t2 stall", 32'(stall_if), 1);
    chk("t2 issue", 32'(issue), 0);
    chk("t2 sel1", 32'(fwd_sel_1), 0);
    drive(1, 6, 1, 1, 1, 7, 1, 0, 0, 0);
    chk("t2 sel1 late", 32'(fwd_sel_1), 2);
    chk("t2 issue late", 32'(issue), 1);
    chk("t2 count", stall_count, 1);
    nop(); nop();
    // x0 never forwards; youngest of two x3 producers wins
    drive(1, 1, 1, 0, 0, 0, 1, 1, 0, 0);
    drive(1, 0, 1, 0, 1, 9, 1, 0, 0, 0);
    chk("t3 x0 sel1", 32'(fwd_sel_1), 0);
    chk("t3 x0 stall", 32'(stall_if), 0);
    chk("t3 x0 issue", 32'(issue), 1);
    drive(1, 1, 1, 0, 0, 3, 1, 0, 0, 0);
    drive(1, 2, 1, 0, 0, 3, 1, 0, 0, 0);
    drive(1, 3, 1, 3, 1, 4, 1, 0, 0, 0);
    chk("t3 young sel1", 32'(fwd_sel_1), 1);
    chk("t3 young sel2", 32'(fwd_sel_2), 1);
    nop(); nop();
    // redirect with FLUSH_SLOTS=2
    drive(1, 1, 1, 0, 0, 8, 1, 0, 1, 0);
    chk("t4 flush a", 32'(flush_id), 1);
    chk("t4 issue a", 32'(issue), 0);
    chk("t4 stall a", 32'(stall_if), 0);
    drive(1, 1, 1, 0, 0, 8, 1, 0, 0, 0);
    chk("t4 flush b", 32'(flush_id), 1);
    chk("t4 issue b", 32'(issue), 0);
    drive(1, 2, 1, 0, 0, 6, 1, 1, 0, 0);
    chk("t4 flush end", 32'(flush_id), 0);
    chk("t4 issue end", 32'(issue), 1);
    drive(1, 6, 1, 0, 0, 7, 1, 0, 1, 0);
    chk("t4 lu redir stall", 32'(stall_if), 0);
    chk("t4 lu redir flush", 32'(flush_id), 1);
    nop(); nop(); nop();
    // ext_stall during a load-use
    drive(1, 2, 1, 0, 0, 6, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(1, 6, 1, 1, 1, 7, 1, 0, 0, 1);
      chk("t5 frozen issue", 32'(issue), 0);
      chk("t5 frozen stall", 32'(stall_if), 1);
      chk("t5 frozen sel1", 32'(fwd_sel_1), 0);
    end
    drive(1, 6, 1, 1, 1, 7, 1, 0, 0, 0);
    chk("t5 lu stall", 32'(stall_if), 1);
    drive(1, 6, 1, 1, 1, 7, 1, 0, 0, 0);
    chk("t5 sel1", 32'(fwd_sel_1), 2);
    chk("t5 issue", 32'(issue), 1);
    chk("t5 count", stall_count, 5);
    nop(); nop();
    // ext_stall masks a redirect; no flush follows
    drive(1, 1, 1, 0, 0, 8, 1, 0, 1, 1);
    chk("t5 xs redir flush", 32'(flush_id), 0);
    chk("t5 xs redir issue", 32'(issue), 0);
    drive(1, 1, 1, 0, 0, 8, 1, 0, 0, 0);
    chk("t5 no flush", 32'(flush_id), 0);
    chk("t5 issue after", 32'(issue), 1);
    nop(); nop();
    // reset right after a load issues
    drive(1, 2, 1, 0, 0, 6, 1, 1, 0, 0);
    @(posedge clk);
    #1 reset = 1;
    setin(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    @(posedge clk);
    #1 reset = 0;
    setin(1, 6, 1, 1, 1, 7, 1, 0, 0, 0);
    @(negedge clk);
    chk("t6 sel1", 32'(fwd_sel_1), 0);
    chk("t6 stall", 32'(stall_if), 0);
    chk("t6 issue", 32'(issue), 1);
    chk("t6 count", stall_count, 0);
    nop(); nop();
    chk_en = 0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
